axi4lite_wr_issuer: RTL and testbench
=====================================

# axi4lite_wr_issuer

Downstream write-issue stage of the AXI4-to-AXI4-Lite bridge. Consumes one pre-split single-beat write command and one matching write-data beat at a time. Issues each pair as a single AXI4-Lite AW/W transaction and collects every AXI4-Lite B response. Folds the responses of one burst into a single AXI4 B response tagged with the burst ID, returned to the AXI4 master.

## Interface
- axi4_id_size, 5, ID width
- axi4_addr_size, 32, address width
- axi4_data_size, 64, data width; strobe width is axi4_data_size/8
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  per-beat write command valid
- cmd_ready  out  1  command accepted
- cmd_addr  in  axi4_addr_size  beat address, already computed upstream
- cmd_id  in  axi4_id_size  AXI4 burst ID
- cmd_prot  in  3  protection bits
- cmd_last  in  1  final beat of burst
- wdat_valid  in  1  write beat valid
- wdat_ready  out  1  write beat accepted
- wdat_data  in  axi4_data_size  write data
- wdat_strb  in  axi4_data_size/8  byte strobes
- wdat_last  in  1  WLAST of the beat
- m_axi4lite_aw_valid/ready  out/in  1  Lite AW handshake
- m_axi4lite_aw_addr  out  axi4_addr_size  Lite address
- m_axi4lite_aw_prot  out  3  Lite prot
- m_axi4lite_w_valid/ready  out/in  1  Lite W handshake
- m_axi4lite_w_data  out  axi4_data_size  Lite data
- m_axi4lite_w_strb  out  axi4_data_size/8  Lite strobes
- m_axi4lite_b_valid/ready  in/out  1  Lite B handshake
- m_axi4lite_b_resp  in  2  Lite response
- s_axi4_b_valid/ready  out/in  1  AXI4 B handshake
- s_axi4_b_id  out  axi4_id_size  burst ID
- s_axi4_b_resp  out  2  merged burst response

## Operation
FSM states and transitions:
- IDLE
  - cmd_ready = wdat_ready = cmd_valid & wdat_valid, so both are consumed in the same cycle or neither is.
  - On accept: register addr, prot, id, last, data and strb, then go to ISSUE.
- ISSUE
  - aw_valid and w_valid assert together.
  - Each drops the cycle after its own handshake. aw_done and w_done flags are tracked independently.
  - When both are done, go to RESP. This includes both completing in the same cycle.
- RESP
  - m_axi4lite_b_ready = 1.
  - On b_valid: merge the response into acc_resp.
  - If the registered last = 1, go to BRSP; otherwise go to IDLE.
- BRSP
  - s_axi4_b_valid = 1, s_axi4_b_id = registered id, s_axi4_b_resp = acc_resp.
  - On s_axi4_b_ready: clear acc_resp to OKAY and go to IDLE.

Response merge:
- Map EXOKAY (01) to OKAY before merging.
- acc_resp = max(acc_resp, mapped resp), giving priority DECERR (11) > SLVERR (10) > OKAY (00).

Handshake and boundary rules:
- m_axi4lite_b_ready is 0 outside RESP. A Lite B that arrives early is held off by the slave until RESP.
- All outputs driven from registers or from state decode only. No combinational path from any *_ready input to any *_valid output.
- Valid outputs and their payloads stay stable until the handshake completes.
- A burst whose first beat has cmd_last = 1 is a single-beat burst and is handled identically.
- Reset mid-operation:
  - Next edge returns to IDLE, acc_resp = OKAY, and all valids/readys go to 0.
  - Any in-flight Lite transaction is abandoned and no B response is emitted.

## Timing
- Reset values:
  - All valid and ready outputs 0.
  - m_axi4lite_aw_addr, aw_prot, w_data, w_strb 0.
  - s_axi4_b_id 0, s_axi4_b_resp 00.
- Best case for a non-last beat: accept at T, Lite AW/W handshake at T+1, Lite B at T+2, next accept at T+3. Throughput is one beat per 3 cycles.
- Last beat: same sequence, then s_axi4_b_valid is first high at T+3.
- cmd_ready and wdat_ready are never high outside IDLE.

## Configuration
- AXI4LITE_WR_LAST_CHECK_EN
  - Defined: on accept, if wdat_last != cmd_last, a sticky mismatch flag is set for the burst. When set, s_axi4_b_resp is forced to SLVERR (10) unless acc_resp is DECERR. The flag clears with acc_resp.
  - Undefined: wdat_last is ignored (port retained, unused) and cmd_last alone delimits bursts.

## Test plan
- Single beat: addr 0x1000, data 0xDEADBEEF, strb 0xFF, id 3, last=1, Lite B OKAY -> one Lite AW/W with 0x1000/0xDEADBEEF, s_axi4_b_valid at T+3 with id 3, resp 00.
- 4-beat burst, addrs 0x2000/08/10/18, Lite B OKAY, SLVERR, EXOKAY, OKAY -> four Lite writes in order, exactly one AXI4 B with resp 10.
- Lite aw_ready held low 5 cycles while w_ready is high -> w_valid drops after 1 cycle, aw_valid stays high with stable addr, no RESP before the AW handshake.
- s_axi4_b_ready held low 4 cycles with a new cmd pending -> cmd_ready stays 0 until the B handshake, then acc_resp returns to 00.
- rst asserted in ISSUE -> next cycle all valids 0, no B emitted. A following single-beat burst with Lite B DECERR returns resp 11.
- With AXI4LITE_WR_LAST_CHECK_EN: 2-beat burst where wdat_last = 1 on beat 0, Lite B OKAY on both beats -> AXI4 B resp 10.

Source files
------------

// File: rtl/axi4lite_wr_issuer_if.sv
// Bus bundle for axi4lite_wr_issuer: the pre-split per-beat command and
// write-data inputs, the AXI4-Lite AW/W/B master channels and the folded
// AXI4 B response channel back toward the AXI4 master.
// The issuer attaches through modport master; the surrounding environment
// (upstream splitter, Lite slave, AXI4 master) attaches through modport slave.
interface axi4lite_wr_issuer_if #(
  parameter int axi4_id_size   = 5,
  parameter int axi4_addr_size = 32,
  parameter int axi4_data_size = 64
);
  localparam int strb_size = axi4_data_size / 8;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [axi4_addr_size-1:0] cmd_addr;
  logic [axi4_id_size-1:0]   cmd_id;
  logic [2:0]                cmd_prot;
  logic                      cmd_last;

  logic                      wdat_valid;
  logic                      wdat_ready;
  logic [axi4_data_size-1:0] wdat_data;
  logic [strb_size-1:0]      wdat_strb;
  logic                      wdat_last;

  logic                      m_axi4lite_aw_valid;
  logic                      m_axi4lite_aw_ready;
  logic [axi4_addr_size-1:0] m_axi4lite_aw_addr;
  logic [2:0]                m_axi4lite_aw_prot;

  logic                      m_axi4lite_w_valid;
  logic                      m_axi4lite_w_ready;
  logic [axi4_data_size-1:0] m_axi4lite_w_data;
  logic [strb_size-1:0]      m_axi4lite_w_strb;

  logic                      m_axi4lite_b_valid;
  logic                      m_axi4lite_b_ready;
  logic [1:0]                m_axi4lite_b_resp;

  logic                      s_axi4_b_valid;
  logic                      s_axi4_b_ready;
  logic [axi4_id_size-1:0]   s_axi4_b_id;
  logic [1:0]                s_axi4_b_resp;

  modport master (
    input  cmd_valid, cmd_addr, cmd_id, cmd_prot, cmd_last,
    output cmd_ready,
    input  wdat_valid, wdat_data, wdat_strb, wdat_last,
    output wdat_ready,
    output m_axi4lite_aw_valid, m_axi4lite_aw_addr, m_axi4lite_aw_prot,
    input  m_axi4lite_aw_ready,
    output m_axi4lite_w_valid, m_axi4lite_w_data, m_axi4lite_w_strb,
    input  m_axi4lite_w_ready,
    input  m_axi4lite_b_valid, m_axi4lite_b_resp,
    output m_axi4lite_b_ready,
    output s_axi4_b_valid, s_axi4_b_id, s_axi4_b_resp,
    input  s_axi4_b_ready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_id, cmd_prot, cmd_last,
    input  cmd_ready,
    output wdat_valid, wdat_data, wdat_strb, wdat_last,
    input  wdat_ready,
    input  m_axi4lite_aw_valid, m_axi4lite_aw_addr, m_axi4lite_aw_prot,
    output m_axi4lite_aw_ready,
    input  m_axi4lite_w_valid, m_axi4lite_w_data, m_axi4lite_w_strb,
    output m_axi4lite_w_ready,
    output m_axi4lite_b_valid, m_axi4lite_b_resp,
    input  m_axi4lite_b_ready,
    input  s_axi4_b_valid, s_axi4_b_id, s_axi4_b_resp,
    output s_axi4_b_ready
  );
endinterface

// File: rtl/axi4lite_wr_issuer.sv
// axi4lite_wr_issuer: write-issue stage of the AXI4-to-AXI4-Lite bridge.
// Takes one single-beat write command plus its data beat, issues it as one
// AXI4-Lite AW/W pair, collects the Lite B, and folds all B responses of a
// burst into one AXI4 B tagged with the burst ID.
// Optional feature macro: AXI4LITE_WR_LAST_CHECK_EN -- when defined, a beat
// whose WLAST disagrees with the command's last flag forces the burst's
// AXI4 response to SLVERR (DECERR still wins).
module axi4lite_wr_issuer #(
  parameter int axi4_id_size   = 5,
  parameter int axi4_addr_size = 32,
  parameter int axi4_data_size = 64
) (
  input logic                  clk,
  input logic                  rst,
  axi4lite_wr_issuer_if.master bus
);
  localparam int strb_size = axi4_data_size / 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP,
    BRSP
  } state_t;

  state_t                    state;
  logic [axi4_addr_size-1:0] addr_q;
  logic [2:0]                prot_q;
  logic [axi4_id_size-1:0]   id_q;
  logic                      last_q;
  logic [axi4_data_size-1:0] data_q;
  logic [strb_size-1:0]      strb_q;
  logic                      aw_valid_q;
  logic                      w_valid_q;
  logic                      aw_done;
  logic                      w_done;
  logic [1:0]                acc_resp;

  logic                      accept;
  logic                      aw_hs;
  logic                      w_hs;
  logic                      aw_fin;
  logic                      w_fin;
  logic [1:0]                mapped_resp;
  logic [1:0]                merged_resp;
  logic [1:0]                b_resp_out;

  // Command and data are only ever taken together, and only while idle.
  assign accept = (state == IDLE) && bus.cmd_valid && bus.wdat_valid;
  assign aw_hs  = aw_valid_q && bus.m_axi4lite_aw_ready;
  assign w_hs   = w_valid_q && bus.m_axi4lite_w_ready;
  assign aw_fin = aw_done || aw_hs;
  assign w_fin  = w_done || w_hs;

  // EXOKAY has no meaning for a folded burst response, so treat it as OKAY;
  // the numeric encoding then orders OKAY < SLVERR < DECERR directly.
  always_comb begin
    mapped_resp = bus.m_axi4lite_b_resp;
    if (bus.m_axi4lite_b_resp == RESP_EXOKAY) begin
      mapped_resp = RESP_OKAY;
    end
  end

  assign merged_resp = (mapped_resp > acc_resp) ? mapped_resp : acc_resp;

  // Issue FSM: latch a beat, run AW and W independently, wait for the Lite B,
  // and at the end of a burst hold the merged AXI4 B until it is taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      prot_q     <= '0;
      id_q       <= '0;
      last_q     <= 1'b0;
      data_q     <= '0;
      strb_q     <= '0;
      aw_valid_q <= 1'b0;
      w_valid_q  <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      acc_resp   <= RESP_OKAY;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            addr_q     <= bus.cmd_addr;
            prot_q     <= bus.cmd_prot;
            id_q       <= bus.cmd_id;
            last_q     <= bus.cmd_last;
            data_q     <= bus.wdat_data;
            strb_q     <= bus.wdat_strb;
            aw_valid_q <= 1'b1;
            w_valid_q  <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            state      <= ISSUE;
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            aw_valid_q <= 1'b0;
            aw_done    <= 1'b1;
          end
          if (w_hs) begin
            w_valid_q <= 1'b0;
            w_done    <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            state <= RESP;
          end
        end
        RESP: begin
          if (bus.m_axi4lite_b_valid) begin
            acc_resp <= merged_resp;
            state    <= last_q ? BRSP : IDLE;
          end
        end
        BRSP: begin
          if (bus.s_axi4_b_ready) begin
            acc_resp <= RESP_OKAY;
            state    <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef AXI4LITE_WR_LAST_CHECK_EN
  logic mismatch_q;

  // Sticky per-burst flag: any beat whose WLAST disagreed with its command's
  // last marker taints the whole burst; it clears together with acc_resp.
  always_ff @(posedge clk) begin
    if (rst) begin
      mismatch_q <= 1'b0;
    end else if ((state == BRSP) && bus.s_axi4_b_ready) begin
      mismatch_q <= 1'b0;
    end else if (accept && (bus.wdat_last != bus.cmd_last)) begin
      mismatch_q <= 1'b1;
    end
  end

  // A framing mismatch reports SLVERR, but a decode error is still the
  // stronger statement and is passed through unchanged.
  assign b_resp_out = (mismatch_q && (acc_resp != RESP_DECERR)) ? RESP_SLVERR : acc_resp;
`else
  logic unused_wdat_last;

  // Without the check, bursts are delimited by cmd_last alone.
  assign unused_wdat_last = bus.wdat_last;
  assign b_resp_out       = acc_resp;
`endif

  // Upstream readies come only from idle-state decode and the two valids, so
  // no ready input ever reaches a valid output.
  assign bus.cmd_ready  = accept;
  assign bus.wdat_ready = accept;

  assign bus.m_axi4lite_aw_valid = aw_valid_q;
  assign bus.m_axi4lite_aw_addr  = addr_q;
  assign bus.m_axi4lite_aw_prot  = prot_q;

  assign bus.m_axi4lite_w_valid = w_valid_q;
  assign bus.m_axi4lite_w_data  = data_q;
  assign bus.m_axi4lite_w_strb  = strb_q;

  assign bus.m_axi4lite_b_ready = (state == RESP);

  assign bus.s_axi4_b_valid = (state == BRSP);
  assign bus.s_axi4_b_id    = id_q;
  assign bus.s_axi4_b_resp  = b_resp_out;
endmodule

// File: tb/tb_axi4lite_wr_issuer.sv
// Testbench for axi4lite_wr_issuer: a table of single beats with hand-computed
// Lite payloads and folded burst responses, driven against an ideal Lite
// slave with optional AW stalls and AXI4 B back-pressure, plus hand-written
// sequences for reset values, partial-valid gating and reset in mid-issue.
// With AXI4LITE_WR_LAST_CHECK_EN defined, extra vectors cover WLAST mismatch.
module tb_axi4lite_wr_issuer;
  localparam int ID_W   = 5;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct {
    logic [31:0] addr;
    logic [63:0] data;
    logic [7:0]  strb;
    logic [4:0]  id;
    logic [2:0]  prot;
    logic        last;
    logic        wlast;
    logic [1:0]  bresp;
    logic [1:0]  exp_resp;
    int          aw_stall;
    int          b_hold;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;
  vec_t vecs[$];

  axi4lite_wr_issuer_if #(
    .axi4_id_size  (ID_W),
    .axi4_addr_size(ADDR_W),
    .axi4_data_size(DATA_W)
  ) bus ();

  axi4lite_wr_issuer #(
    .axi4_id_size  (ID_W),
    .axi4_addr_size(ADDR_W),
    .axi4_data_size(DATA_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish (got timeout, required finish)");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkVec(input logic [31:0] addr, input logic [63:0] data,
                                 input logic [7:0] strb, input logic [4:0] id,
                                 input logic [2:0] prot, input logic last, input logic wlast,
                                 input logic [1:0] bresp, input logic [1:0] exp_resp,
                                 input int aw_stall, input int b_hold);
    vec_t v;
    v.addr     = addr;
    v.data     = data;
    v.strb     = strb;
    v.id       = id;
    v.prot     = prot;
    v.last     = last;
    v.wlast    = wlast;
    v.bresp    = bresp;
    v.exp_resp = exp_resp;
    v.aw_stall = aw_stall;
    v.b_hold   = b_hold;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Runs one beat end to end. Called just after a falling edge with the DUT
  // idle; returns just after a falling edge with the DUT idle again.
  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("v%0d", idx);
    bus.cmd_valid           = 1'b1;
    bus.cmd_addr            = v.addr;
    bus.cmd_id              = v.id;
    bus.cmd_prot            = v.prot;
    bus.cmd_last            = v.last;
    bus.wdat_valid          = 1'b1;
    bus.wdat_data           = v.data;
    bus.wdat_strb           = v.strb;
    bus.wdat_last           = v.wlast;
    bus.m_axi4lite_aw_ready = (v.aw_stall == 0);
    bus.m_axi4lite_w_ready  = 1'b1;
    bus.m_axi4lite_b_valid  = 1'b0;
    bus.s_axi4_b_ready      = 1'b0;
    #1;
    checkOutput({tag, " cmd_ready"}, 64'(bus.cmd_ready), 64'd1);
    checkOutput({tag, " wdat_ready"}, 64'(bus.wdat_ready), 64'd1);

    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.wdat_valid = 1'b0;
    #1;
    checkOutput({tag, " aw_valid"}, 64'(bus.m_axi4lite_aw_valid), 64'd1);
    checkOutput({tag, " w_valid"}, 64'(bus.m_axi4lite_w_valid), 64'd1);
    checkOutput({tag, " aw_addr"}, 64'(bus.m_axi4lite_aw_addr), 64'(v.addr));
    checkOutput({tag, " aw_prot"}, 64'(bus.m_axi4lite_aw_prot), 64'(v.prot));
    checkOutput({tag, " w_data"}, bus.m_axi4lite_w_data, v.data);
    checkOutput({tag, " w_strb"}, 64'(bus.m_axi4lite_w_strb), 64'(v.strb));
    checkOutput({tag, " b_ready in issue"}, 64'(bus.m_axi4lite_b_ready), 64'd0);

    for (int i = 0; i < v.aw_stall; i++) begin
      @(negedge clk);
      #1;
      checkOutput({tag, " stall w_valid"}, 64'(bus.m_axi4lite_w_valid), 64'd0);
      checkOutput({tag, " stall aw_valid"}, 64'(bus.m_axi4lite_aw_valid), 64'd1);
      checkOutput({tag, " stall aw_addr"}, 64'(bus.m_axi4lite_aw_addr), 64'(v.addr));
      checkOutput({tag, " stall b_ready"}, 64'(bus.m_axi4lite_b_ready), 64'd0);
      bus.m_axi4lite_b_valid = 1'b1;
      bus.m_axi4lite_b_resp  = v.bresp;
      if (i == v.aw_stall - 1) begin
        bus.m_axi4lite_aw_ready = 1'b1;
      end
    end

    @(negedge clk);
    #1;
    checkOutput({tag, " aw_valid dropped"}, 64'(bus.m_axi4lite_aw_valid), 64'd0);
    checkOutput({tag, " w_valid dropped"}, 64'(bus.m_axi4lite_w_valid), 64'd0);
    checkOutput({tag, " b_ready in resp"}, 64'(bus.m_axi4lite_b_ready), 64'd1);
    bus.m_axi4lite_b_valid = 1'b1;
    bus.m_axi4lite_b_resp  = v.bresp;

    @(negedge clk);
    bus.m_axi4lite_b_valid = 1'b0;
    #1;
    checkOutput({tag, " b_ready after b"}, 64'(bus.m_axi4lite_b_ready), 64'd0);
    if (v.last) begin
      checkOutput({tag, " s_b_valid"}, 64'(bus.s_axi4_b_valid), 64'd1);
      checkOutput({tag, " s_b_id"}, 64'(bus.s_axi4_b_id), 64'(v.id));
      checkOutput({tag, " s_b_resp"}, 64'(bus.s_axi4_b_resp), 64'(v.exp_resp));
      if (v.b_hold > 0) begin
        bus.cmd_valid  = 1'b1;
        bus.wdat_valid = 1'b1;
      end
      for (int i = 0; i < v.b_hold; i++) begin
        #1;
        checkOutput({tag, " hold cmd_ready"}, 64'(bus.cmd_ready), 64'd0);
        checkOutput({tag, " hold s_b_valid"}, 64'(bus.s_axi4_b_valid), 64'd1);
        checkOutput({tag, " hold s_b_resp"}, 64'(bus.s_axi4_b_resp), 64'(v.exp_resp));
        @(negedge clk);
      end
      bus.s_axi4_b_ready = 1'b1;
      @(negedge clk);
      bus.s_axi4_b_ready = 1'b0;
      #1;
      checkOutput({tag, " s_b_valid after hs"}, 64'(bus.s_axi4_b_valid), 64'd0);
      if (v.b_hold > 0) begin
        checkOutput({tag, " cmd_ready after hs"}, 64'(bus.cmd_ready), 64'd1);
        bus.cmd_valid  = 1'b0;
        bus.wdat_valid = 1'b0;
      end
    end else begin
      checkOutput({tag, " no s_b_valid mid-burst"}, 64'(bus.s_axi4_b_valid), 64'd0);
    end
  endtask

  initial begin
    bus.cmd_valid           = 1'b0;
    bus.cmd_addr            = '0;
    bus.cmd_id              = '0;
    bus.cmd_prot            = '0;
    bus.cmd_last            = 1'b0;
    bus.wdat_valid          = 1'b0;
    bus.wdat_data           = '0;
    bus.wdat_strb           = '0;
    bus.wdat_last           = 1'b0;
    bus.m_axi4lite_aw_ready = 1'b0;
    bus.m_axi4lite_w_ready  = 1'b0;
    bus.m_axi4lite_b_valid  = 1'b0;
    bus.m_axi4lite_b_resp   = OKAY;
    bus.s_axi4_b_ready      = 1'b0;

    // addr, data, strb, id, prot, last, wlast, lite bresp, expected burst resp, aw stall, b hold
    vecs.push_back(mkVec(32'h1000, 64'h0000_0000_DEAD_BEEF, 8'hFF, 5'd3, 3'd0, 1'b1, 1'b1, OKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h2000, 64'h1111_0000_0000_0001, 8'hFF, 5'd5, 3'd1, 1'b0, 1'b0, OKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h2008, 64'h2222_0000_0000_0002, 8'h0F, 5'd5, 3'd1, 1'b0, 1'b0, SLVERR, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h2010, 64'h3333_0000_0000_0003, 8'hF0, 5'd5, 3'd1, 1'b0, 1'b0, EXOKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h2018, 64'h4444_0000_0000_0004, 8'hFF, 5'd5, 3'd1, 1'b1, 1'b1, OKAY, SLVERR, 0, 0));
    vecs.push_back(mkVec(32'h3000, 64'h0000_0000_0000_A5A5, 8'h0F, 5'd2, 3'd2, 1'b0, 1'b0, SLVERR, OKAY, 5, 0));
    vecs.push_back(mkVec(32'h3008, 64'hCAFE_F00D_0000_0000, 8'hC3, 5'd2, 3'd2, 1'b1, 1'b1, OKAY, SLVERR, 0, 4));
    vecs.push_back(mkVec(32'h4000, 64'h0102_0304_0506_0708, 8'h81, 5'd9, 3'd7, 1'b1, 1'b1, OKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h6000, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 5'd31, 3'd4, 1'b1, 1'b1, EXOKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h7000, 64'h0000_0000_0000_0070, 8'hFF, 5'd12, 3'd0, 1'b0, 1'b0, DECERR, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h7008, 64'h0000_0000_0000_0078, 8'hFF, 5'd12, 3'd0, 1'b1, 1'b1, SLVERR, DECERR, 0, 0));
`ifdef AXI4LITE_WR_LAST_CHECK_EN
    vecs.push_back(mkVec(32'h8000, 64'h0000_0000_0000_0080, 8'hFF, 5'd4, 3'd0, 1'b0, 1'b1, OKAY, OKAY, 0, 0));
    vecs.push_back(mkVec(32'h8008, 64'h0000_0000_0000_0088, 8'hFF, 5'd4, 3'd0, 1'b1, 1'b1, OKAY, SLVERR, 0, 0));
`endif

    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset cmd_ready", 64'(bus.cmd_ready), 64'd0);
    checkOutput("reset wdat_ready", 64'(bus.wdat_ready), 64'd0);
    checkOutput("reset aw_valid", 64'(bus.m_axi4lite_aw_valid), 64'd0);
    checkOutput("reset w_valid", 64'(bus.m_axi4lite_w_valid), 64'd0);
    checkOutput("reset b_ready", 64'(bus.m_axi4lite_b_ready), 64'd0);
    checkOutput("reset s_b_valid", 64'(bus.s_axi4_b_valid), 64'd0);
    checkOutput("reset aw_addr", 64'(bus.m_axi4lite_aw_addr), 64'd0);
    checkOutput("reset aw_prot", 64'(bus.m_axi4lite_aw_prot), 64'd0);
    checkOutput("reset w_data", bus.m_axi4lite_w_data, 64'd0);
    checkOutput("reset w_strb", 64'(bus.m_axi4lite_w_strb), 64'd0);
    checkOutput("reset s_b_id", 64'(bus.s_axi4_b_id), 64'd0);
    checkOutput("reset s_b_resp", 64'(bus.s_axi4_b_resp), 64'd0);
    rst = 1'b0;

    bus.cmd_valid = 1'b1;
    #1;
    checkOutput("cmd only cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bus.cmd_valid  = 1'b0;
    bus.wdat_valid = 1'b1;
    #1;
    checkOutput("wdat only wdat_ready", 64'(bus.wdat_ready), 64'd0);
    bus.wdat_valid = 1'b0;
    @(negedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i], i);
    end

    applyStimulus(mkVec(32'h5000, 64'h0123_4567_89AB_CDEF, 8'hFF, 5'd6, 3'd0, 1'b0, 1'b0, SLVERR, OKAY, 0, 0), 90);
    bus.cmd_valid           = 1'b1;
    bus.cmd_addr            = 32'h5008;
    bus.cmd_id              = 5'd6;
    bus.cmd_prot            = 3'd0;
    bus.cmd_last            = 1'b1;
    bus.wdat_valid          = 1'b1;
    bus.wdat_data           = 64'h0000_0000_0000_5008;
    bus.wdat_strb           = 8'hFF;
    bus.wdat_last           = 1'b1;
    bus.m_axi4lite_aw_ready = 1'b0;
    bus.m_axi4lite_w_ready  = 1'b0;
    #1;
    checkOutput("rst seq cmd_ready", 64'(bus.cmd_ready), 64'd1);
    @(negedge clk);
    bus.cmd_valid  = 1'b0;
    bus.wdat_valid = 1'b0;
    #1;
    checkOutput("rst seq aw_valid in issue", 64'(bus.m_axi4lite_aw_valid), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checkOutput("rst seq aw_valid", 64'(bus.m_axi4lite_aw_valid), 64'd0);
    checkOutput("rst seq w_valid", 64'(bus.m_axi4lite_w_valid), 64'd0);
    checkOutput("rst seq b_ready", 64'(bus.m_axi4lite_b_ready), 64'd0);
    checkOutput("rst seq s_b_valid", 64'(bus.s_axi4_b_valid), 64'd0);
    checkOutput("rst seq aw_addr", 64'(bus.m_axi4lite_aw_addr), 64'd0);
    rst                     = 1'b0;
    bus.m_axi4lite_aw_ready = 1'b1;
    bus.m_axi4lite_w_ready  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkOutput("post-rst aw_valid", 64'(bus.m_axi4lite_aw_valid), 64'd0);
      checkOutput("post-rst b_ready", 64'(bus.m_axi4lite_b_ready), 64'd0);
      checkOutput("post-rst s_b_valid", 64'(bus.s_axi4_b_valid), 64'd0);
    end
    applyStimulus(mkVec(32'h9000, 64'h0000_0000_0000_9000, 8'hFF, 5'd8, 3'd0, 1'b1, 1'b1, OKAY, OKAY, 0, 0), 91);
    applyStimulus(mkVec(32'h9008, 64'h0000_0000_0000_9008, 8'hFF, 5'd10, 3'd5, 1'b1, 1'b1, DECERR, DECERR, 0, 0), 92);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
